// File: rtl/simmem_mock_mem_ctrl.sv
// ---------------------------------------------------------------------------
// simmem_mock_mem_ctrl
//
// Synthesisable stand-in for a memory controller. Accepts write and read
// requests, holds them in one circular queue per channel and answers them in
// request order after a fixed latency: a single write response per write,
// a burst of read beats per read. The two channels share nothing but the
// clock and reset.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   wreq_id_i              write request ID
//   wreq_valid_i/ready_o   write request handshake
//   rreq_id_i              read request ID
//   rreq_burst_len_i       read beat count (0 is treated as 1)
//   rreq_valid_i/ready_o   read request handshake
//   wresp_id_o             write response ID (0 while not valid)
//   wresp_valid_o/ready_i  write response handshake
//   rdata_id_o             read-data ID (0 while not valid)
//   rdata_data_o           {zero padding, id, beat index}
//   rdata_last_o           final beat of the burst
//   rdata_valid_o/ready_i  read-data handshake
// ---------------------------------------------------------------------------
module simmem_mock_mem_ctrl #(
    parameter int IdWidth      = 4,
    parameter int DataWidth    = 32,
    parameter int MaxBurstLenW = 3,
    parameter int QueueDepth   = 4,
    parameter int WLatency     = 8,
    parameter int RLatency     = 12
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [IdWidth-1:0]      wreq_id_i,
    input  logic                    wreq_valid_i,
    output logic                    wreq_ready_o,
    input  logic [IdWidth-1:0]      rreq_id_i,
    input  logic [MaxBurstLenW:0]   rreq_burst_len_i,
    input  logic                    rreq_valid_i,
    output logic                    rreq_ready_o,
    output logic [IdWidth-1:0]      wresp_id_o,
    output logic                    wresp_valid_o,
    input  logic                    wresp_ready_i,
    output logic [IdWidth-1:0]      rdata_id_o,
    output logic [DataWidth-1:0]    rdata_data_o,
    output logic                    rdata_last_o,
    output logic                    rdata_valid_o,
    input  logic                    rdata_ready_i
);

    localparam int PtrW  = $clog2(QueueDepth);
    localparam int LenW  = MaxBurstLenW + 1;
    localparam int WAgeW = $clog2(WLatency + 1);
    localparam int RAgeW = $clog2(RLatency + 1);

    localparam logic [WAgeW-1:0] WLAT    = WAgeW'(WLatency);
    localparam logic [RAgeW-1:0] RLAT    = RAgeW'(RLatency);
    localparam logic [PtrW:0]    FULL_XOR = {1'b1, {PtrW{1'b0}}};
    localparam logic [PtrW:0]    PTR_ONE  = (PtrW+1)'(1);

    // =======================================================================
    // Write channel
    // =======================================================================
    logic [PtrW:0]         w_wr_ptr_q, w_wr_ptr_d;
    logic [PtrW:0]         w_rd_ptr_q, w_rd_ptr_d;
    logic [IdWidth-1:0]    w_id_q  [QueueDepth];
    logic [IdWidth-1:0]    w_id_d  [QueueDepth];
    logic [WAgeW-1:0]      w_age_q [QueueDepth];
    logic [WAgeW-1:0]      w_age_d [QueueDepth];
    logic [QueueDepth-1:0] w_slot_sel;
    logic                  w_full, w_empty, w_push, w_pop;
    logic [PtrW-1:0]       w_head;

    assign w_full  = ((w_wr_ptr_q ^ w_rd_ptr_q) == FULL_XOR);
    assign w_empty = (w_wr_ptr_q == w_rd_ptr_q);
    assign w_head  = w_rd_ptr_q[PtrW-1:0];

    assign wreq_ready_o  = ~w_full;
    // Ages saturate at the latency, so equality is the ">= latency" test.
    assign wresp_valid_o = ~w_empty & (w_age_q[w_head] == WLAT);
    assign wresp_id_o    = wresp_valid_o ? w_id_q[w_head] : '0;

    assign w_push = wreq_valid_i & ~w_full;
    assign w_pop  = wresp_valid_o & wresp_ready_i;

    for (genvar gi = 0; gi < QueueDepth; gi++) begin : gen_w_sel
        assign w_slot_sel[gi] = w_push & (w_wr_ptr_q[PtrW-1:0] == PtrW'(gi));
    end

    // The handshake cycle itself counts as age 0, so the slot holds 1 in the
    // first cycle after the push; the response is then valid exactly
    // WLatency cycles after the handshake cycle.
    always_comb begin
        w_wr_ptr_d = w_push ? w_wr_ptr_q + PTR_ONE : w_wr_ptr_q;
        w_rd_ptr_d = w_pop  ? w_rd_ptr_q + PTR_ONE : w_rd_ptr_q;
        for (int i = 0; i < QueueDepth; i++) begin
            w_id_d[i]  = w_id_q[i];
            w_age_d[i] = w_age_q[i];
            if (w_slot_sel[i]) begin
                w_id_d[i]  = wreq_id_i;
                w_age_d[i] = WAgeW'(1);
            end else if (w_age_q[i] != WLAT) begin
                w_age_d[i] = w_age_q[i] + WAgeW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_wr_ptr_q <= '0;
            w_rd_ptr_q <= '0;
            for (int i = 0; i < QueueDepth; i++) begin
                w_id_q[i]  <= '0;
                w_age_q[i] <= '0;
            end
        end else begin
            w_wr_ptr_q <= w_wr_ptr_d;
            w_rd_ptr_q <= w_rd_ptr_d;
            for (int i = 0; i < QueueDepth; i++) begin
                w_id_q[i]  <= w_id_d[i];
                w_age_q[i] <= w_age_d[i];
            end
        end
    end

    // =======================================================================
    // Read channel
    // =======================================================================
    logic [PtrW:0]         r_wr_ptr_q, r_wr_ptr_d;
    logic [PtrW:0]         r_rd_ptr_q, r_rd_ptr_d;
    logic [IdWidth-1:0]    r_id_q  [QueueDepth];
    logic [IdWidth-1:0]    r_id_d  [QueueDepth];
    logic [LenW-1:0]       r_len_q [QueueDepth];
    logic [LenW-1:0]       r_len_d [QueueDepth];
    logic [RAgeW-1:0]      r_age_q [QueueDepth];
    logic [RAgeW-1:0]      r_age_d [QueueDepth];
    logic [QueueDepth-1:0] r_slot_sel;
    logic [LenW-1:0]       beat_q, beat_d;
    logic [LenW-1:0]       r_last_idx;
    logic                  r_full, r_empty, r_push, r_hs, r_pop;
    logic [PtrW-1:0]       r_head;

    assign r_full  = ((r_wr_ptr_q ^ r_rd_ptr_q) == FULL_XOR);
    assign r_empty = (r_wr_ptr_q == r_rd_ptr_q);
    assign r_head  = r_rd_ptr_q[PtrW-1:0];

    // A zero length behaves as a single-beat burst.
    assign r_last_idx = (r_len_q[r_head] == '0) ? '0 : r_len_q[r_head] - LenW'(1);

    assign rreq_ready_o  = ~r_full;
    // Only the first beat waits for the age; the head stays eligible for the
    // rest of its burst, so later beats stream back-to-back.
    assign rdata_valid_o = ~r_empty & (r_age_q[r_head] == RLAT);
    assign rdata_id_o    = rdata_valid_o ? r_id_q[r_head] : '0;
    assign rdata_data_o  = rdata_valid_o ? DataWidth'({r_id_q[r_head], beat_q}) : '0;
    assign rdata_last_o  = rdata_valid_o & (beat_q == r_last_idx);

    assign r_push = rreq_valid_i & ~r_full;
    assign r_hs   = rdata_valid_o & rdata_ready_i;
    assign r_pop  = r_hs & rdata_last_o;

    for (genvar gi = 0; gi < QueueDepth; gi++) begin : gen_r_sel
        assign r_slot_sel[gi] = r_push & (r_wr_ptr_q[PtrW-1:0] == PtrW'(gi));
    end

    always_comb begin
        r_wr_ptr_d = r_push ? r_wr_ptr_q + PTR_ONE : r_wr_ptr_q;
        r_rd_ptr_d = r_pop  ? r_rd_ptr_q + PTR_ONE : r_rd_ptr_q;
        beat_d     = beat_q;
        if (r_pop) begin
            beat_d = '0;
        end else if (r_hs) begin
            beat_d = beat_q + LenW'(1);
        end
        for (int i = 0; i < QueueDepth; i++) begin
            r_id_d[i]  = r_id_q[i];
            r_len_d[i] = r_len_q[i];
            r_age_d[i] = r_age_q[i];
            if (r_slot_sel[i]) begin
                r_id_d[i]  = rreq_id_i;
                r_len_d[i] = rreq_burst_len_i;
                r_age_d[i] = RAgeW'(1);
            end else if (r_age_q[i] != RLAT) begin
                r_age_d[i] = r_age_q[i] + RAgeW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            beat_q     <= '0;
            for (int i = 0; i < QueueDepth; i++) begin
                r_id_q[i]  <= '0;
                r_len_q[i] <= '0;
                r_age_q[i] <= '0;
            end
        end else begin
            r_wr_ptr_q <= r_wr_ptr_d;
            r_rd_ptr_q <= r_rd_ptr_d;
            beat_q     <= beat_d;
            for (int i = 0; i < QueueDepth; i++) begin
                r_id_q[i]  <= r_id_d[i];
                r_len_q[i] <= r_len_d[i];
                r_age_q[i] <= r_age_d[i];
            end
        end
    end

endmodule

// File: doc/simmem_mock_mem_ctrl.md
# simmem_mock_mem_ctrl

- Synthesisable stand-in for the real memory controller.
- Takes the simulated-memory request stream and produces the AXI write responses and read-data bursts that feed the response banks' `wresp`/`rdata` input ports.
- Delivers responses in request order per channel after a fixed, parameterised latency.
- Provides a self-contained responder for block- and system-level benches.

## Interface

Parameters:
- `IdWidth`, default 4: AXI identifier width.
- `DataWidth`, default 32: read-data width. Must satisfy `DataWidth >= IdWidth + MaxBurstLenW + 1`.
- `MaxBurstLenW`, default 3: width of burst length minus one. The burst length port is `MaxBurstLenW+1` bits and holds the beat count.
- `QueueDepth`, default 4: outstanding requests per channel. Power of two, at least 2.
- `WLatency`, default 8: write-response latency in cycles, at least 1.
- `RLatency`, default 12: first-beat read latency in cycles, at least 1.

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset. Asynchronous, active-low.
- `wreq_id_i`, in, `IdWidth`: write request ID.
- `wreq_valid_i` / `wreq_ready_o`, in / out, 1: write request handshake.
- `rreq_id_i`, in, `IdWidth`: read request ID.
- `rreq_burst_len_i`, in, `MaxBurstLenW+1`: number of beats.
- `rreq_valid_i` / `rreq_ready_o`, in / out, 1: read request handshake.
- `wresp_id_o`, out, `IdWidth`: write response ID.
- `wresp_valid_o`, out, 1: write response valid. Pairs with `wresp_ready_i`, in, 1.
- `rdata_id_o`, out, `IdWidth`: read-data ID.
- `rdata_data_o`, out, `DataWidth`: read-data payload.
- `rdata_last_o`, out, 1: final beat of a burst.
- `rdata_valid_o`, out, 1: read-data valid. Pairs with `rdata_ready_i`, in, 1.

## Operation

Queues:
- Each channel has one circular queue of `QueueDepth` entries.
- Write entries hold {id, age counter}. Read entries hold {id, beat count, age counter}.
- The queue's read and write pointers are `log2(QueueDepth)+1` bits. The extra MSB distinguishes full from empty:
  - Full: pointers differ only in the MSB.
  - Empty: pointers are equal.

Request acceptance:
- `*_ready_o` is high exactly when the queue is not full, and depends only on registered state.
- There is no combinational path from `*_ready_i` to `*_ready_o`. When the queue is full, a same-cycle dequeue does not open ready.
- A handshake pushes the entry with its age set to 0.
- Each entry's age saturates at its latency.

Write channel:
- `wresp_valid_o` is high when the head entry has age >= `WLatency`.
- `wresp_id_o` is the head entry's ID.
- A handshake pops the head.

Read channel:
- The head entry becomes eligible at age >= `RLatency`.
- A beat counter `beat_q` (`MaxBurstLenW+1` bits) starts at 0.
- `rdata_valid_o` is high while the head is eligible.
- `rdata_data_o` = {zero padding, id, `beat_q`}, with `beat_q` in the LSBs.
- `rdata_last_o` = (`beat_q` == effective length − 1).
- Each handshake increments `beat_q`. The handshake carrying last pops the head and clears `beat_q`.
- A burst length of 0 is treated as 1.
- Later beats stream back-to-back. The latency applies only to the first beat.

Output stability:
- While valid is high and ready is low, every output field holds stable.
- Valid never drops without a handshake.

The two channels are fully independent.

## Timing

Reset:
- Both queues empty, `beat_q` = 0, all ages = 0.
- `wreq_ready_o` = `rreq_ready_o` = 1.
- All valid, ID, data and last outputs are 0.
- Reset asserted mid-burst discards all queued entries and any partial burst. No beat is emitted after reset is released until new requests arrive.

Latency:
- A request whose handshake occurs in cycle T has its response valid at the earliest in cycle T+`WLatency` (write) or T+`RLatency` (first read beat).
- It is exactly at that cycle if the entry is at the head and the previous response was accepted.

Throughput and simultaneity:
- One request accepted and one response/beat delivered per channel per cycle.
- Simultaneous push and pop is legal when the queue is not full.
- Pointers wrap modulo `2*QueueDepth`.

Ordering:
- Queued entries age in parallel.
- A non-head entry that has already reached its latency responds in the cycle immediately after the head pops.

## Test plan

- **Reset defaults.** Reset, then idle 20 cycles → readies 1, valids 0, all outputs 0.
- **Single write.** Write ID 3 accepted at cycle 10, `WLatency`=8, `wresp_ready_i`=1 → `wresp_valid_o` rises at cycle 18 with ID 3 and drops at cycle 19.
- **Read burst.** Read ID 5, len 4, `RLatency`=12, ready held high → beats at cycles T+12..T+15, data LSBs 0,1,2,3, ID field 5, last only on beat 3.
- **Write full condition.** Push 4 writes while `wresp_ready_i`=0 → `wreq_ready_o` falls after the 4th handshake. A 5th request stalls. `wresp_id_o` is held stable with ready low. Releasing ready returns IDs in push order, and `wreq_ready_o` rises the cycle after the first pop.
- **Backpressure and wrap.** Random `rdata_ready_i` at 50% over 64 reads with lengths 0–8 → beat counts, data and last are correct, no beat is lost or duplicated, and pointers wrap correctly.
- **Reset mid-burst.** Assert `rst_ni` low during beat 2 of an 8-beat burst → outputs are 0 immediately. After release, no stale beats are emitted, and a fresh read responds after exactly `RLatency` cycles.
